decode_forward_stage: RTL and testbench
=======================================

Name: decode_forward_stage

Overview:
- Decode stage of the pipelined Y86-64 core.
- Takes the fetched D-register fields and derives srcA, srcB, dstE and dstM. The source IDs go combinationally to the register file, and valA/valB come back from it.
- Applies data forwarding from the execute, memory and write-back stages to the returned values.
- Latches the result into the E pipeline register, with stall and bubble control from the pipeline control unit.

Parameters:
- W, 64, data width of every value bus.
- RNONE, 4'hF, register ID meaning "no register".
- RRSP, 4'h4, register ID of %rsp.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- D_stat  in  4  status of the instruction in D (1 AOK, 2 HLT, 3 ADR, 4 INS).
- D_icode, D_ifun  in  4 each  instruction code and function.
- D_rA, D_rB  in  4 each  register specifier fields.
- D_valC, D_valP  in  W each  constant word and next PC.
- d_srcA, d_srcB  out  4 each  combinational source IDs sent to the register file.
- rf_valA, rf_valB  in  W each  register-file read data (0 when the ID is RNONE).
- e_dstE  in  4, e_valE  in  W  execute-stage result after the cmov condition.
- M_dstE, M_dstM  in  4 each; M_valE  in  W; m_valM  in  W  memory stage.
- W_dstE, W_dstM  in  4 each; W_valE, W_valM  in  W each  write-back stage.
- E_stall, E_bubble  in  1 each  pipeline control.
- E_stat, E_icode, E_ifun  out  4 each  registered.
- E_valC, E_valA, E_valB  out  W each  registered.
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  registered.

Behaviour:
- ID decode (combinational, on D_icode):
  - srcA = D_rA for 2, 4, 6, A; RRSP for 9, B; else RNONE.
  - srcB = D_rB for 4, 5, 6; RRSP for 8, 9, A, B; else RNONE.
  - dstE = D_rB for 2, 3, 6; RRSP for 8, 9, A, B; else RNONE.
  - dstM = D_rA for 5, B; else RNONE.
- d_srcA and d_srcB are driven directly from this decode.
- d_valA selection, first match wins:
  1. D_icode is 7 or 8: D_valP.
  2. srcA == RNONE: 0.
  3. srcA == e_dstE: e_valE.
  4. srcA == M_dstM: m_valM.
  5. srcA == M_dstE: M_valE.
  6. srcA == W_dstM: W_valM.
  7. srcA == W_dstE: W_valE.
  8. Otherwise: rf_valA.
- d_valB selection: the same chain on srcB, without the valP case.
- Compare against a dst ID only when that ID is not RNONE; RNONE never matches.
- Priority is fixed: the most recent stage wins, and within the M and W stages the dstM value beats the dstE value. Example: popq %rsp has M_dstE = M_dstM = 4, and valM is selected.
- E register update on posedge clk:
  - rst = 1: load bubble. Bubble values are stat = 1, icode = 1 (nop), ifun = 0, valC/valA/valB = 0, dstE/dstM/srcA/srcB = RNONE.
  - Else E_stall = 1: hold all E outputs.
  - Else E_bubble = 1: load bubble.
  - Else: load D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB, dstE, dstM, srcA, srcB.
- Priority is rst > E_stall > E_bubble. With stall and bubble both high, E holds.
- rst asserted mid-stream: after the next edge E is a bubble, regardless of stall, bubble or in-flight data.
- Latency: one cycle from D fields to E outputs. There is no combinational path from D inputs to E outputs.
- Unknown icodes (C to F) decode all IDs to RNONE. D_stat (INS) passes through unchanged, and this stage raises no exceptions.
- All value buses are treated as raw W-bit values; no arithmetic is done here.

Test Plan:
- Reset: hold rst high for 2 cycles with arbitrary D inputs, then release with stall and bubble low and D = nop.
  - Required: E_icode = 1, E_stat = 1, all E IDs = F, all E vals = 0.
- OPq forward from execute: D = icode 6, rA = 2, rB = 3; e_dstE = 2, e_valE = 0x55; W_dstE = 2, W_valE = 0x99; rf_valA = 0x11; rf_valB = 0x22.
  - Required: d_srcA = 2 and d_srcB = 3 the same cycle.
  - Required after the edge: E_valA = 0x55, E_valB = 0x22, E_dstE = 3.
- popq %rsp priority: D = pushq rA = 4 (srcA = 4, srcB = 4); M_dstE = 4, M_valE = 0x100; M_dstM = 4, m_valM = 0x200.
  - Required: E_valA = E_valB = 0x200.
- call: D = icode 8, D_valP = 0x40, with e_dstE = 4 and e_valE = 0x7.
  - Required: E_valA = 0x40, E_valB = 0x7, E_dstE = 4, E_dstM = F.
- Stall and bubble: load an irmovq (valC = 0x1234, rB = 5) into E, then assert E_stall for 2 cycles while changing D, then assert E_bubble with E_stall, then assert E_bubble alone.
  - Required: E holds irmovq through the stall cycles and the combined cycle.
  - Required: E becomes nop, all IDs F, after the bubble-alone edge.
- RNONE guard: D = irmovq (srcA = srcB = F) with e_dstE = F and e_valE = 0xDEAD.
  - Required: E_valA = E_valB = 0, not 0xDEAD.

Source files
------------

// File: rtl/decode_forward_stage_if.sv
// Bundle of D-register fields, register-file read path, forwarding sources,
// pipeline control and E-register outputs for the decode stage.
interface decode_forward_stage_if #(
    parameter int W = 64
);
    logic [3:0]   D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [W-1:0] D_valC, D_valP;

    logic [3:0]   d_srcA, d_srcB;
    logic [W-1:0] rf_valA, rf_valB;

    logic [3:0]   e_dstE;
    logic [W-1:0] e_valE;
    logic [3:0]   M_dstE, M_dstM;
    logic [W-1:0] M_valE, m_valM;
    logic [3:0]   W_dstE, W_dstM;
    logic [W-1:0] W_valE, W_valM;

    logic         E_stall, E_bubble;

    logic [3:0]   E_stat, E_icode, E_ifun;
    logic [W-1:0] E_valC, E_valA, E_valB;
    logic [3:0]   E_dstE, E_dstM, E_srcA, E_srcB;

    modport master (
        output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        output rf_valA, rf_valB,
        output e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
        output W_dstE, W_dstM, W_valE, W_valM,
        output E_stall, E_bubble,
        input  d_srcA, d_srcB,
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        input  E_dstE, E_dstM, E_srcA, E_srcB
    );

    modport slave (
        input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        input  rf_valA, rf_valB,
        input  e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
        input  W_dstE, W_dstM, W_valE, W_valM,
        input  E_stall, E_bubble,
        output d_srcA, d_srcB,
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        output E_dstE, E_dstM, E_srcA, E_srcB
    );
endinterface

// File: rtl/decode_forward_stage.sv
// Y86-64 decode stage: register-ID decode, operand forwarding from E/M/W,
// and the E pipeline register with stall/bubble control.
module decode_forward_stage #(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = 4'hF,
    parameter logic [3:0] RRSP  = 4'h4
) (
    input logic                  clk,
    input logic                  rst,
    decode_forward_stage_if.slave bus
);
    typedef struct packed {
        logic [3:0]   stat;
        logic [3:0]   icode;
        logic [3:0]   ifun;
        logic [W-1:0] valC;
        logic [W-1:0] valA;
        logic [W-1:0] valB;
        logic [3:0]   dstE;
        logic [3:0]   dstM;
        logic [3:0]   srcA;
        logic [3:0]   srcB;
    } e_reg_t;

    localparam e_reg_t E_BUBBLE = '{
        stat: 4'h1, icode: 4'h1, ifun: 4'h0,
        valC: '0, valA: '0, valB: '0,
        dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE
    };

    logic [3:0]   src_a, src_b, dst_e, dst_m;
    logic [W-1:0] d_val_a, d_val_b;
    e_reg_t       e_d, e_q;

    // Most recent stage wins; within M and W the memory result beats the ALU result.
    function automatic logic [W-1:0] forward_value(
        input logic [3:0]   src,
        input logic [W-1:0] rf_val,
        input logic [3:0]   e_dst_e, input logic [W-1:0] e_val_e,
        input logic [3:0]   m_dst_m, input logic [W-1:0] m_val_m,
        input logic [3:0]   m_dst_e, input logic [W-1:0] m_val_e,
        input logic [3:0]   w_dst_m, input logic [W-1:0] w_val_m,
        input logic [3:0]   w_dst_e, input logic [W-1:0] w_val_e
    );
        if (src == RNONE)                             return '0;
        else if (e_dst_e != RNONE && src == e_dst_e)  return e_val_e;
        else if (m_dst_m != RNONE && src == m_dst_m)  return m_val_m;
        else if (m_dst_e != RNONE && src == m_dst_e)  return m_val_e;
        else if (w_dst_m != RNONE && src == w_dst_m)  return w_val_m;
        else if (w_dst_e != RNONE && src == w_dst_e)  return w_val_e;
        else                                          return rf_val;
    endfunction

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;

        if (bus.D_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) src_a = bus.D_rA;
        else if (bus.D_icode inside {4'h9, 4'hB})        src_a = RRSP;

        if (bus.D_icode inside {4'h4, 4'h5, 4'h6})             src_b = bus.D_rB;
        else if (bus.D_icode inside {4'h8, 4'h9, 4'hA, 4'hB})  src_b = RRSP;

        if (bus.D_icode inside {4'h2, 4'h3, 4'h6})             dst_e = bus.D_rB;
        else if (bus.D_icode inside {4'h8, 4'h9, 4'hA, 4'hB})  dst_e = RRSP;

        if (bus.D_icode inside {4'h5, 4'hB}) dst_m = bus.D_rA;
    end

    // jXX and call carry valP through the valA slot instead of a register.
    always_comb begin
        d_val_a = '0;
        d_val_b = '0;
        if (bus.D_icode == 4'h7 || bus.D_icode == 4'h8)
            d_val_a = bus.D_valP;
        else
            d_val_a = forward_value(src_a, bus.rf_valA,
                                    bus.e_dstE, bus.e_valE, bus.M_dstM, bus.m_valM,
                                    bus.M_dstE, bus.M_valE, bus.W_dstM, bus.W_valM,
                                    bus.W_dstE, bus.W_valE);
        d_val_b = forward_value(src_b, bus.rf_valB,
                                bus.e_dstE, bus.e_valE, bus.M_dstM, bus.m_valM,
                                bus.M_dstE, bus.M_valE, bus.W_dstM, bus.W_valM,
                                bus.W_dstE, bus.W_valE);
    end

    // Stall outranks bubble, so both high holds the register.
    always_comb begin
        e_d = e_q;
        if (!bus.E_stall) begin
            if (bus.E_bubble) begin
                e_d = E_BUBBLE;
            end else begin
                e_d.stat  = bus.D_stat;
                e_d.icode = bus.D_icode;
                e_d.ifun  = bus.D_ifun;
                e_d.valC  = bus.D_valC;
                e_d.valA  = d_val_a;
                e_d.valB  = d_val_b;
                e_d.dstE  = dst_e;
                e_d.dstM  = dst_m;
                e_d.srcA  = src_a;
                e_d.srcB  = src_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) e_q <= E_BUBBLE;
        else     e_q <= e_d;
    end

    assign bus.d_srcA  = src_a;
    assign bus.d_srcB  = src_b;
    assign bus.E_stat  = e_q.stat;
    assign bus.E_icode = e_q.icode;
    assign bus.E_ifun  = e_q.ifun;
    assign bus.E_valC  = e_q.valC;
    assign bus.E_valA  = e_q.valA;
    assign bus.E_valB  = e_q.valB;
    assign bus.E_dstE  = e_q.dstE;
    assign bus.E_dstM  = e_q.dstM;
    assign bus.E_srcA  = e_q.srcA;
    assign bus.E_srcB  = e_q.srcB;
endmodule

// File: tb/tb_decode_forward_stage.sv
// Directed and randomized checks of decode_forward_stage against a
// table-driven reference of the Y86-64 decode and forwarding rules.
module tb_decode_forward_stage;
    localparam int W = 64;
    localparam logic [3:0] NONE = 4'hF;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    decode_forward_stage_if #(.W(W)) bus ();

    decode_forward_stage #(.W(W), .RNONE(4'hF), .RRSP(4'h4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   stat, icode, ifun;
        logic [W-1:0] valC, valA, valB;
        logic [3:0]   dstE, dstM, srcA, srcB;
    } e_model_t;

    e_model_t exp_e;
    e_model_t bubble_e = '{stat: 4'h1, icode: 4'h1, ifun: 4'h0, valC: '0, valA: '0,
                           valB: '0, dstE: NONE, dstM: NONE, srcA: NONE, srcB: NONE};

    // Register roles per icode: 0 none, 1 rA, 2 rB, 3 %rsp.
    int role_srcA[16] = '{0,0,1,0,1,0,1,0,0,3,1,3,0,0,0,0};
    int role_srcB[16] = '{0,0,0,0,2,2,2,0,3,3,3,3,0,0,0,0};
    int role_dstE[16] = '{0,0,2,2,0,0,2,0,3,3,3,3,0,0,0,0};
    int role_dstM[16] = '{0,0,0,0,0,1,0,0,0,0,0,1,0,0,0,0};

    function automatic logic [3:0] pick_role(int role);
        case (role)
            1:       return bus.D_rA;
            2:       return bus.D_rB;
            3:       return 4'h4;
            default: return NONE;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_forward(logic [3:0] src, logic [W-1:0] rf_val);
        logic [3:0]   dsts[5];
        logic [W-1:0] vals[5];
        dsts = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
        vals = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
        if (src == NONE) return '0;
        for (int i = 0; i < 5; i++)
            if (dsts[i] != NONE && dsts[i] == src) return vals[i];
        return rf_val;
    endfunction

    task automatic checkOutput(string tag, logic [W-1:0] observed, logic [W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One cycle: check combinational source IDs, advance the model, clock, check E.
    task automatic applyStimulus();
        logic [3:0] sa, sb;
        #1;
        sa = pick_role(role_srcA[bus.D_icode]);
        sb = pick_role(role_srcB[bus.D_icode]);
        checkOutput("d_srcA", {60'd0, bus.d_srcA}, {60'd0, sa});
        checkOutput("d_srcB", {60'd0, bus.d_srcB}, {60'd0, sb});
        if (rst) exp_e = bubble_e;
        else if (bus.E_stall) exp_e = exp_e;
        else if (bus.E_bubble) exp_e = bubble_e;
        else begin
            exp_e.stat  = bus.D_stat;
            exp_e.icode = bus.D_icode;
            exp_e.ifun  = bus.D_ifun;
            exp_e.valC  = bus.D_valC;
            exp_e.valA  = (bus.D_icode == 4'h7 || bus.D_icode == 4'h8) ? bus.D_valP
                                                                       : ref_forward(sa, bus.rf_valA);
            exp_e.valB  = ref_forward(sb, bus.rf_valB);
            exp_e.dstE  = pick_role(role_dstE[bus.D_icode]);
            exp_e.dstM  = pick_role(role_dstM[bus.D_icode]);
            exp_e.srcA  = sa;
            exp_e.srcB  = sb;
        end
        @(posedge clk);
        #1;
        checkOutput("E_stat",  {60'd0, bus.E_stat},  {60'd0, exp_e.stat});
        checkOutput("E_icode", {60'd0, bus.E_icode}, {60'd0, exp_e.icode});
        checkOutput("E_ifun",  {60'd0, bus.E_ifun},  {60'd0, exp_e.ifun});
        checkOutput("E_valC",  bus.E_valC, exp_e.valC);
        checkOutput("E_valA",  bus.E_valA, exp_e.valA);
        checkOutput("E_valB",  bus.E_valB, exp_e.valB);
        checkOutput("E_dstE",  {60'd0, bus.E_dstE},  {60'd0, exp_e.dstE});
        checkOutput("E_dstM",  {60'd0, bus.E_dstM},  {60'd0, exp_e.dstM});
        checkOutput("E_srcA",  {60'd0, bus.E_srcA},  {60'd0, exp_e.srcA});
        checkOutput("E_srcB",  {60'd0, bus.E_srcB},  {60'd0, exp_e.srcB});
    endtask

    function automatic logic [3:0] rand_reg();
        int r = $urandom_range(0, 7);
        return (r == 7) ? NONE : 4'(r);
    endfunction

    function automatic logic [W-1:0] rand_val();
        return {$urandom, $urandom};
    endfunction

    task automatic setD(logic [3:0] icode, logic [3:0] rA, logic [3:0] rB,
                        logic [W-1:0] valC, logic [W-1:0] valP);
        bus.D_stat  = 4'h1;
        bus.D_icode = icode;
        bus.D_ifun  = 4'h0;
        bus.D_rA    = rA;
        bus.D_rB    = rB;
        bus.D_valC  = valC;
        bus.D_valP  = valP;
    endtask

    task automatic clearFwd();
        bus.e_dstE = NONE; bus.e_valE = rand_val();
        bus.M_dstE = NONE; bus.M_valE = rand_val();
        bus.M_dstM = NONE; bus.m_valM = rand_val();
        bus.W_dstE = NONE; bus.W_valE = rand_val();
        bus.W_dstM = NONE; bus.W_valM = rand_val();
        bus.rf_valA = rand_val();
        bus.rf_valB = rand_val();
        bus.E_stall  = 1'b0;
        bus.E_bubble = 1'b0;
    endtask

    task automatic randomizeAll();
        bus.D_stat  = 4'($urandom_range(1, 4));
        bus.D_icode = 4'($urandom_range(0, 15));
        bus.D_ifun  = 4'($urandom_range(0, 15));
        bus.D_rA    = rand_reg();
        bus.D_rB    = rand_reg();
        bus.D_valC  = rand_val();
        bus.D_valP  = rand_val();
        clearFwd();
        bus.e_dstE = rand_reg();
        bus.M_dstE = rand_reg();
        bus.M_dstM = rand_reg();
        bus.W_dstE = rand_reg();
        bus.W_dstM = rand_reg();
        bus.E_stall  = ($urandom_range(0, 5) == 0);
        bus.E_bubble = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        rst = 1'b1;
        randomizeAll();
        applyStimulus();
        randomizeAll();
        applyStimulus();

        rst = 1'b0;
        setD(4'h1, NONE, NONE, '0, 64'h2);
        clearFwd();
        applyStimulus();
        checkOutput("reset_icode", {60'd0, bus.E_icode}, 64'h1);
        checkOutput("reset_dstE",  {60'd0, bus.E_dstE},  64'hF);
        checkOutput("reset_valA",  bus.E_valA, 64'h0);

        setD(4'h6, 4'h2, 4'h3, '0, 64'h10);
        clearFwd();
        bus.e_dstE = 4'h2; bus.e_valE = 64'h55;
        bus.W_dstE = 4'h2; bus.W_valE = 64'h99;
        bus.rf_valA = 64'h11; bus.rf_valB = 64'h22;
        applyStimulus();
        checkOutput("opq_valA", bus.E_valA, 64'h55);
        checkOutput("opq_valB", bus.E_valB, 64'h22);
        checkOutput("opq_dstE", {60'd0, bus.E_dstE}, 64'h3);

        setD(4'hA, 4'h4, NONE, '0, 64'h12);
        clearFwd();
        bus.M_dstE = 4'h4; bus.M_valE = 64'h100;
        bus.M_dstM = 4'h4; bus.m_valM = 64'h200;
        applyStimulus();
        checkOutput("pop_rsp_valA", bus.E_valA, 64'h200);
        checkOutput("pop_rsp_valB", bus.E_valB, 64'h200);

        setD(4'h8, NONE, NONE, 64'h80, 64'h40);
        clearFwd();
        bus.e_dstE = 4'h4; bus.e_valE = 64'h7;
        applyStimulus();
        checkOutput("call_valA", bus.E_valA, 64'h40);
        checkOutput("call_valB", bus.E_valB, 64'h7);
        checkOutput("call_dstE", {60'd0, bus.E_dstE}, 64'h4);
        checkOutput("call_dstM", {60'd0, bus.E_dstM}, 64'hF);

        setD(4'h3, NONE, 4'h5, 64'h1234, 64'h20);
        clearFwd();
        applyStimulus();
        for (int i = 0; i < 2; i++) begin
            randomizeAll();
            bus.E_stall = 1'b1; bus.E_bubble = 1'b0;
            applyStimulus();
            checkOutput("stall_valC", bus.E_valC, 64'h1234);
            checkOutput("stall_dstE", {60'd0, bus.E_dstE}, 64'h5);
        end
        randomizeAll();
        bus.E_stall = 1'b1; bus.E_bubble = 1'b1;
        applyStimulus();
        checkOutput("stall_bubble_icode", {60'd0, bus.E_icode}, 64'h3);
        randomizeAll();
        bus.E_stall = 1'b0; bus.E_bubble = 1'b1;
        applyStimulus();
        checkOutput("bubble_icode", {60'd0, bus.E_icode}, 64'h1);
        checkOutput("bubble_dstE",  {60'd0, bus.E_dstE},  64'hF);
        checkOutput("bubble_srcB",  {60'd0, bus.E_srcB},  64'hF);

        setD(4'h3, NONE, 4'h5, 64'h77, 64'h30);
        clearFwd();
        bus.e_valE = 64'hDEAD;
        bus.rf_valA = '0; bus.rf_valB = '0;
        applyStimulus();
        checkOutput("rnone_valA", bus.E_valA, 64'h0);
        checkOutput("rnone_valB", bus.E_valB, 64'h0);

        for (int i = 0; i < 300; i++) begin
            randomizeAll();
            rst = ($urandom_range(0, 30) == 0);
            applyStimulus();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
